// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for a 5-stage pipeline.
// Optional feature macro: LOAD_USE_CNT_EN (adds saturating load_use_cnt output).
module fwd_hazard_ctrl #(
    parameter int REG_W    = 5,
    parameter int ZERO_REG = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_is_load,
    input  logic             flush,
    input  logic             hold,
    output logic             stall_id,
    output logic             fwd_a_mem,
    output logic             fwd_a_wb,
    output logic             fwd_b_mem,
    output logic             fwd_b_wb,
`ifdef LOAD_USE_CNT_EN
    output logic [31:0]      load_use_cnt,
`endif
    output logic             ex_valid
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic             is_load;
    } tag_t;

    localparam logic [REG_W-1:0] ZERO_R = REG_W'(ZERO_REG);

    tag_t ex_q, mem_q, id_tag;
    logic lu, bubble;
    logic a_mem_d, a_wb_d, b_mem_d, b_wb_d;
    logic a_mem_q, a_wb_q, b_mem_q, b_wb_q, ex_valid_q;

    function automatic logic writes(input tag_t t, input logic [REG_W-1:0] r);
        return t.valid & t.reg_write & (t.rd == r) & (r != ZERO_R);
    endfunction

    always_comb begin
        lu       = id_valid & ex_q.is_load &
                   ((id_use_rs1 & writes(ex_q, id_rs1)) | (id_use_rs2 & writes(ex_q, id_rs2)));
        stall_id = lu & ~flush & ~hold & ~reset;
        bubble   = flush | lu | ~id_valid;

        // A producing load in EX never forwards from MEM; that case is the load-use stall.
        a_mem_d  = id_use_rs1 & writes(ex_q, id_rs1) & ~ex_q.is_load;
        a_wb_d   = id_use_rs1 & writes(mem_q, id_rs1) & ~a_mem_d;
        b_mem_d  = id_use_rs2 & writes(ex_q, id_rs2) & ~ex_q.is_load;
        b_wb_d   = id_use_rs2 & writes(mem_q, id_rs2) & ~b_mem_d;

        id_tag.valid     = 1'b1;
        id_tag.rd        = id_rd;
        id_tag.reg_write = id_reg_write;
        id_tag.is_load   = id_is_load;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q       <= '0;
            mem_q      <= '0;
            a_mem_q    <= 1'b0;
            a_wb_q     <= 1'b0;
            b_mem_q    <= 1'b0;
            b_wb_q     <= 1'b0;
            ex_valid_q <= 1'b0;
        end else if (!hold) begin
            mem_q <= ex_q;
            if (bubble) begin
                ex_q       <= '0;
                a_mem_q    <= 1'b0;
                a_wb_q     <= 1'b0;
                b_mem_q    <= 1'b0;
                b_wb_q     <= 1'b0;
                ex_valid_q <= 1'b0;
            end else begin
                ex_q       <= id_tag;
                a_mem_q    <= a_mem_d;
                a_wb_q     <= a_wb_d;
                b_mem_q    <= b_mem_d;
                b_wb_q     <= b_wb_d;
                ex_valid_q <= 1'b1;
            end
        end
    end

    assign fwd_a_mem = a_mem_q;
    assign fwd_a_wb  = a_wb_q;
    assign fwd_b_mem = b_mem_q;
    assign fwd_b_wb  = b_wb_q;
    assign ex_valid  = ex_valid_q;

`ifdef LOAD_USE_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (stall_id && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
    end

    // stall_id is already low under hold, so the count freezes there too.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign load_use_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed scenarios plus random traffic
// checked against an in-flight-instruction reference model.
module tb_fwd_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset, id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_is_load, flush, hold;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       stall_id, fwd_a_mem, fwd_a_wb, fwd_b_mem, fwd_b_wb, ex_valid;
`ifdef LOAD_USE_CNT_EN
    logic [31:0] load_use_cnt;
`endif

    fwd_hazard_ctrl #(.REG_W(5), .ZERO_REG(31)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush), .hold(hold),
        .stall_id(stall_id), .fwd_a_mem(fwd_a_mem), .fwd_a_wb(fwd_a_wb),
        .fwd_b_mem(fwd_b_mem), .fwd_b_wb(fwd_b_wb),
`ifdef LOAD_USE_CNT_EN
        .load_use_cnt(load_use_cnt),
`endif
        .ex_valid(ex_valid)
    );

    always #5 clk = ~clk;

    // Reference model: the instruction occupying EX and MEM, plus expected outputs.
    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit ld;
    } ins_t;

    ins_t        m_ex, m_mem, n_ex, n_mem;
    logic [4:0]  m_out, n_out;
    logic [31:0] m_cnt, n_cnt;
    logic        exp_stall, obs_stall;
    int          n_checks = 0, n_pass = 0;

    function automatic bit produces(input ins_t t, input int r);
        return t.v && t.rw && (t.rd == r) && (r != 31);
    endfunction

    // 1 = newest producer is in EX, 2 = in MEM, 0 = none (register file value is current).
    function automatic int producer(input int r);
        if (produces(m_ex, r))  return 1;
        if (produces(m_mem, r)) return 2;
        return 0;
    endfunction

    function automatic logic [4:0] obs_vec();
        return {fwd_a_mem, fwd_a_wb, fwd_b_mem, fwd_b_wb, ex_valid};
    endfunction

    task automatic model_eval();
        bit lu;
        int pa, pb;
        ins_t zero;
        zero = '{0, 0, 0, 0};
        lu = id_valid && m_ex.ld &&
             ((id_use_rs1 && produces(m_ex, int'(id_rs1))) || (id_use_rs2 && produces(m_ex, int'(id_rs2))));
        exp_stall = lu && !flush && !hold && !reset;
        n_ex = m_ex; n_mem = m_mem; n_out = m_out; n_cnt = m_cnt;
        if (reset) begin
            n_ex = zero; n_mem = zero; n_out = '0; n_cnt = '0;
        end else if (!hold) begin
            n_mem = m_ex;
            if (flush || lu || !id_valid) begin
                n_ex = zero; n_out = '0;
            end else begin
                pa = producer(int'(id_rs1));
                pb = producer(int'(id_rs2));
                n_out = {id_use_rs1 && pa == 1, id_use_rs1 && pa == 2,
                         id_use_rs2 && pb == 1, id_use_rs2 && pb == 2, 1'b1};
                n_ex = '{1, int'(id_rd), id_reg_write, id_is_load};
            end
            if (exp_stall && m_cnt != 32'hFFFF_FFFF) n_cnt = m_cnt + 1;
        end
    endtask

    // Advance one clock: sample stall_id mid-cycle, then commit the model after the edge.
    task automatic tick();
        @(negedge clk);
        obs_stall = stall_id;
        model_eval();
        @(posedge clk);
        #1;
        m_ex = n_ex; m_mem = n_mem; m_out = n_out; m_cnt = n_cnt;
    endtask

    task automatic set_id(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                          input int rd, input bit rw, input bit ld);
        id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = 5'(rd); id_reg_write = rw; id_is_load = ld;
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; hold = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        set_id(1, 0, 0, 0, 0, 1, 1, 1);        // LDUR X1
        tick();
        set_id(1, 1, 0, 1, 0, 2, 1, 0);        // ADD reads X1, with reset held
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (obs_stall !== 1'b0) $display("FAIL reset_stall got=%b want=0", obs_stall);
        else n_pass++;
        n_checks++;
        if (obs_vec() !== 5'b00000) $display("FAIL reset_outputs got=%b want=00000", obs_vec());
        else n_pass++;
    endtask

    task automatic test_ex_forward();
        do_reset();
        set_id(1, 7, 8, 1, 1, 1, 1, 0);        // ADD X1
        tick();
        set_id(1, 1, 2, 1, 1, 9, 1, 0);        // SUB rs1=X1 rs2=X2
        tick();
        n_checks++;
        if (obs_stall !== 1'b0) $display("FAIL ex_fwd_stall got=%b want=0", obs_stall);
        else n_pass++;
        n_checks++;
        if (obs_vec() !== 5'b10001) $display("FAIL ex_fwd_sel got=%b want=10001", obs_vec());
        else n_pass++;
    endtask

    task automatic test_wb_forward();
        do_reset();
        set_id(1, 0, 0, 0, 0, 3, 1, 0);        // ADD X3
        tick();
        set_id(1, 10, 11, 1, 1, 9, 1, 0);      // unrelated
        tick();
        set_id(1, 12, 3, 1, 1, 13, 1, 0);      // ORR rs2=X3
        tick();
        n_checks++;
        if (obs_vec() !== 5'b00011) $display("FAIL wb_fwd_sel got=%b want=00011", obs_vec());
        else n_pass++;
    endtask

    task automatic test_newest_wins();
        do_reset();
        set_id(1, 0, 0, 0, 0, 4, 1, 0);        // ADD X4
        tick();
        tick();                                 // second ADD X4
        set_id(1, 4, 6, 1, 0, 14, 1, 0);       // AND rs1=X4
        tick();
        n_checks++;
        if (obs_vec() !== 5'b10001) $display("FAIL newest_wins got=%b want=10001", obs_vec());
        else n_pass++;
        do_reset();
        set_id(1, 0, 0, 0, 0, 2, 1, 0);        // ADD X2
        tick();
        set_id(1, 2, 2, 1, 1, 15, 1, 0);       // both sources X2
        tick();
        n_checks++;
        if (obs_vec() !== 5'b10101) $display("FAIL same_src got=%b want=10101", obs_vec());
        else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1, 0, 0, 0, 0, 5, 1, 1);        // LDUR X5
        tick();
        set_id(1, 5, 6, 1, 0, 16, 1, 0);       // ADD rs1=X5
        tick();
        n_checks++;
        if (obs_stall !== 1'b1) $display("FAIL lu_stall got=%b want=1", obs_stall);
        else n_pass++;
        n_checks++;
        if (obs_vec() !== 5'b00000) $display("FAIL lu_bubble got=%b want=00000", obs_vec());
        else n_pass++;
        tick();                                 // retry of the same ADD
        n_checks++;
        if (obs_stall !== 1'b0) $display("FAIL lu_one_cycle got=%b want=0", obs_stall);
        else n_pass++;
        n_checks++;
        if (obs_vec() !== 5'b01001) $display("FAIL lu_retry_sel got=%b want=01001", obs_vec());
        else n_pass++;
`ifdef LOAD_USE_CNT_EN
        n_checks++;
        if (load_use_cnt !== 32'd1) $display("FAIL lu_cnt got=%0d want=1", load_use_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_zero_reg();
        do_reset();
        set_id(1, 0, 0, 0, 0, 31, 1, 0);       // write X31
        tick();
        set_id(1, 31, 31, 1, 1, 17, 1, 0);     // read X31 twice
        tick();
        n_checks++;
        if (obs_vec() !== 5'b00001) $display("FAIL xzr_fwd got=%b want=00001", obs_vec());
        else n_pass++;
        set_id(1, 0, 0, 0, 0, 31, 1, 1);       // LDUR X31
        tick();
        set_id(1, 31, 31, 1, 1, 18, 1, 0);
        tick();
        n_checks++;
        if (obs_stall !== 1'b0 || obs_vec() !== 5'b00001)
            $display("FAIL xzr_load got stall=%b sel=%b want stall=0 sel=00001", obs_stall, obs_vec());
        else n_pass++;
    endtask

    task automatic test_flush_hold_reset();
        do_reset();
        set_id(1, 0, 0, 0, 0, 5, 1, 1);        // LDUR X5
        tick();
        set_id(1, 5, 0, 1, 0, 19, 1, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++;
        if (obs_stall !== 1'b0 || obs_vec() !== 5'b00000)
            $display("FAIL flush got stall=%b sel=%b want stall=0 sel=00000", obs_stall, obs_vec());
        else n_pass++;

        do_reset();
        set_id(1, 0, 0, 0, 0, 1, 1, 0);        // ADD X1
        tick();
        set_id(1, 1, 0, 1, 0, 5, 1, 1);        // LDUR X5 from [X1]
        tick();
        set_id(1, 5, 0, 1, 0, 20, 1, 0);       // ADD rs1=X5
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (obs_stall !== 1'b0 || obs_vec() !== 5'b10001)
                $display("FAIL hold_freeze[%0d] got stall=%b sel=%b want stall=0 sel=10001", i, obs_stall, obs_vec());
            else n_pass++;
        end
        hold = 1'b0;
        tick();
        n_checks++;
        if (obs_stall !== 1'b1 || obs_vec() !== 5'b00000)
            $display("FAIL hold_resume got stall=%b sel=%b want stall=1 sel=00000", obs_stall, obs_vec());
        else n_pass++;

        do_reset();
        set_id(1, 0, 0, 0, 0, 5, 1, 1);        // LDUR X5
        tick();
        set_id(1, 5, 0, 1, 0, 21, 1, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();                                 // same consumer after reset
        n_checks++;
        if (obs_stall !== 1'b0 || obs_vec() !== 5'b00001)
            $display("FAIL reset_mid_stall got stall=%b sel=%b want stall=0 sel=00001", obs_stall, obs_vec());
        else n_pass++;
    endtask

    task automatic test_random();
        int r1, r2, rd;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            r1 = $urandom_range(0, 4); if (r1 == 4) r1 = 31;
            r2 = $urandom_range(0, 4); if (r2 == 4) r2 = 31;
            rd = $urandom_range(0, 4); if (rd == 4) rd = 31;
            set_id($urandom_range(0, 7) != 0, r1, r2, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 1) != 0, rd, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            flush = ($urandom_range(0, 9) == 0);
            hold  = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 49) == 0);
            tick();
            n_checks++;
            if (obs_stall !== exp_stall || obs_vec() !== m_out)
                $display("FAIL random[%0d] got stall=%b sel=%b want stall=%b sel=%b",
                         c, obs_stall, obs_vec(), exp_stall, m_out);
            else n_pass++;
`ifdef LOAD_USE_CNT_EN
            n_checks++;
            if (load_use_cnt !== m_cnt) $display("FAIL random_cnt[%0d] got=%0d want=%0d", c, load_use_cnt, m_cnt);
            else n_pass++;
`endif
        end
        reset = 1'b0; flush = 1'b0; hold = 1'b0;
    endtask

    initial begin
        m_ex = '{0, 0, 0, 0}; m_mem = '{0, 0, 0, 0}; m_out = '0; m_cnt = '0;
        reset = 1'b1; flush = 1'b0; hold = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_ex_forward();
        test_wb_forward();
        test_newest_wins();
        test_load_use();
        test_zero_reg();
        test_flush_hold_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
